rr_mux_sel_scanner: RTL and testbench
=====================================

# rr_mux_sel_scanner

Round-robin select sequencer that drives the `sel[1:0]` and `enable` inputs of the 4-bit 4-to-1 mux stage directly downstream. Four request lines compete for the mux. The scanner grants one channel at a time for a fixed dwell, rotates fairly among active requesters, and deasserts `enable` between grants so that no two channels' data ever appear back-to-back on the mux output.

## Interface
- `DWELL`, default 4: cycles per grant. Legal range 1..255.
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req` input, 4 bits: per-channel request. Bit 0 maps to mux input a, bit 3 to mux input d.
- `hold` input, 1 bit: freezes the state machine and dwell counter while high.
- `sel` output, 2 bits: mux select. Registered.
- `enable` output, 1 bit: mux enable, active-high. Registered.
- `grant_done` output, 1 bit: one-cycle pulse on the last cycle of each grant.

## Operation
- States:
  - IDLE: `enable`=0.
  - GRANT: `enable`=1, `sel`=current channel.
  - GAP: `enable`=0 for one cycle, `sel` held.
- Round-robin pick:
  - `last` pointer holds the most recently granted channel.
  - Search order is `last`+1, `last`+2, `last`+3, `last`, modulo 4.
  - The first channel with `req` high wins.
- IDLE → GRANT: any `req` bit high. Load `sel`=pick, load dwell counter=DWELL-1, set `last`=pick.
- GRANT, per cycle:
  - Counter decrements.
  - When the counter is 0, or when `req[sel]` is low, assert `grant_done` and go to GAP.
- GAP → GRANT when `req`≠0, using the pick from `last`. Otherwise GAP → IDLE.
- Counter arithmetic:
  - 8-bit unsigned, no wrap. The decrement is never applied at 0.
  - DWELL=1 gives a one-cycle grant.
- `hold`=1:
  - State, counter, `last`, `sel` and `enable` are frozen.
  - `grant_done` is forced to 0.
  - A `req` drop during hold takes effect on the first cycle after hold releases.
- Simultaneous events:
  - Counter reaching 0 in the same cycle as a `req[sel]` drop produces a single `grant_done` and a single GAP.
  - `hold` has priority over both.
- A single requester is re-granted after each GAP. No starvation: a waiting channel is granted within 3 grants.

## Timing
- Reset values: `sel`=00, `enable`=0, `grant_done`=0, state=IDLE, `last`=3 (so the first pick searches from channel 0), counter=0.
- `rst` clears all of the above immediately, without waiting for a clock edge, including mid-grant.
- Latency: `req` sampled high at edge N in IDLE → `enable`=1 and `sel` valid after edge N.
- Each grant keeps `enable` high for exactly DWELL cycles unless it is cut short by a `req` drop or extended by `hold`.
- `grant_done` is high during the final `enable`=1 cycle of a grant.
- Grant period with continuous requests: DWELL+1 cycles (DWELL with `SCAN_GAP_EN` undefined).

## Configuration
- `SCAN_GAP_EN` defined:
  - GAP state is present, giving one dead cycle with `enable`=0 between grants.
- `SCAN_GAP_EN` undefined:
  - GAP state is removed. GRANT end goes directly to GRANT of the next pick, or to IDLE if `req`=0.
  - `enable` stays high across back-to-back grants and `sel` changes on the boundary edge.

## Structure
- Package `rr_scan_pkg` holds:
  - state enum: IDLE, GRANT, GAP
  - `NCH`=4
  - `SEL_W`=2
  - `CNT_W`=8
- Sub-module `rr_pick`: purely combinational rotate-priority picker. Inputs are `req[3:0]` and `last[1:0]`; outputs are `pick[1:0]` and `any`.
- The top level contains the FSM, dwell counter and output registers only.

## Test plan
All scenarios use DWELL=4 and `SCAN_GAP_EN` defined unless stated.
- Reset: `rst`=1 with `req`=1111 → `sel`=00, `enable`=0, `grant_done`=0. Assert `rst` mid-grant → `enable` drops to 0 immediately, without waiting for a clock edge.
- Single requester: `req`=0001 → `sel`=00, `enable` high 4 cycles, then low 1 cycle, repeating. `grant_done` pulses on every 4th high cycle.
- Full rotation: `req`=1111 → `sel` sequence 00,01,10,11,00. Each value holds `enable` high for 4 cycles, separated by 1-cycle gaps.
- Sparse/skip: `req`=0101 → `sel` alternates 00,10. `req`=1000 after reset → first grant is `sel`=11.
- Early drop: `req`=0010 granted, `req`→0000 after 2 grant cycles → `grant_done` on cycle 3, `enable`=0 after it, state IDLE.
- Hold and no-gap build:
  - `hold`=1 for 3 cycles mid-grant → `enable` high 7 cycles total, no `grant_done` during hold.
  - Rebuilt without `SCAN_GAP_EN`, `req`=0011 → `enable` continuously 1, `sel` toggles every 4 cycles.

Source files
------------

// File: rtl/rr_scan_pkg.sv
// Shared types and widths for the round-robin mux select scanner.
package rr_scan_pkg;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } scan_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: searches last+1, last+2, last+3, last (mod 4).
module rr_pick
    import rr_scan_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] pick,
    output logic             any
);
    logic [SEL_W-1:0] idx;

    always_comb begin
        pick = last;
        any  = |req;
        idx  = '0;
        // Walk from the farthest offset down so the nearest requester after last wins.
        for (int i = NCH; i >= 1; i--) begin
            idx = last + SEL_W'(i);
            if (req[idx]) pick = idx;
        end
    end
endmodule

// File: rtl/rr_mux_sel_scanner.sv
// Round-robin sel/enable sequencer for a downstream 4-to-1 mux.
// Define SCAN_GAP_EN to insert one enable=0 cycle between consecutive grants.
module rr_mux_sel_scanner
    import rr_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic             hold,
    output logic [SEL_W-1:0] sel,
    output logic             enable,
    output logic             grant_done,
    output logic [1:0]       dbg_state
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DWELL - 1);

    scan_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] pick;
    logic             any;
    logic             grant_end;

    rr_pick u_pick (
        .req  (req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    // Dwell expiry and requester drop collapse into one end-of-grant event; hold masks both.
    assign grant_end  = (state == GRANT) && !hold && ((cnt == '0) || !req[sel]);
    assign grant_done = grant_end;
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= SEL_W'(NCH - 1);
            sel    <= '0;
            enable <= 1'b0;
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state  <= GRANT;
                        sel    <= pick;
                        last   <= pick;
                        cnt    <= LOAD;
                        enable <= 1'b1;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
`ifdef SCAN_GAP_EN
                        state  <= GAP;
                        enable <= 1'b0;
`else
                        if (any) begin
                            state  <= GRANT;
                            sel    <= pick;
                            last   <= pick;
                            cnt    <= LOAD;
                            enable <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            enable <= 1'b0;
                        end
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (any) begin
                        state  <= GRANT;
                        sel    <= pick;
                        last   <= pick;
                        cnt    <= LOAD;
                        enable <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_mux_sel_scanner.sv
// Directed bench for rr_mux_sel_scanner (DWELL=4); expectations follow SCAN_GAP_EN.
module tb_rr_mux_sel_scanner;
    import rr_scan_pkg::*;

    logic           clk;
    logic           rst;
    logic [3:0]     req;
    logic           hold;
    logic [1:0]     sel;
    logic           enable;
    logic           grant_done;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;

    rr_mux_sel_scanner #(.DWELL(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .hold       (hold),
        .sel        (sel),
        .enable     (enable),
        .grant_done (grant_done),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises rst between edges and checks the outputs cleared before any edge.
    task automatic apply_reset();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_en", enable, 1'b0);
        chk("rst_sel", sel, 2'b00);
        chk("rst_done", grant_done, 1'b0);
        chk("rst_state", dbg_state, IDLE);
        step();
        rst = 1'b0;
    endtask

    // Checks one full grant starting at its first enable cycle.
    task automatic grant(input logic [1:0] s, input int n);
        for (int i = 1; i <= n; i++) begin
            chk("gr_en", enable, 1'b1);
            chk("gr_sel", sel, s);
            chk("gr_done", grant_done, (i == n));
            step();
        end
`ifdef SCAN_GAP_EN
        chk("gap_en", enable, 1'b0);
        chk("gap_sel", sel, s);
        chk("gap_done", grant_done, 1'b0);
        step();
`endif
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        hold = 1'b0;
        step();
        step();
        chk("init_sel", sel, 2'b00);
        chk("init_en", enable, 1'b0);
        chk("init_done", grant_done, 1'b0);
        chk("init_state", dbg_state, IDLE);
        rst = 1'b0;

        // Full rotation from reset: 0,1,2,3,0
        step();
        grant(2'd0, 4);
        grant(2'd1, 4);
        grant(2'd2, 4);
        grant(2'd3, 4);
        grant(2'd0, 4);

        // Asynchronous reset in the middle of the grant to channel 1
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en", enable, 1'b0);
        chk("arst_sel", sel, 2'b00);
        chk("arst_state", dbg_state, IDLE);
        step();
        rst = 1'b0;

        // Single requester regranted repeatedly
        req = 4'b0001;
        step();
        grant(2'd0, 4);
        grant(2'd0, 4);
        grant(2'd0, 4);

        // Sparse requesters alternate
        apply_reset();
        req = 4'b0101;
        step();
        grant(2'd0, 4);
        grant(2'd2, 4);
        grant(2'd0, 4);
        grant(2'd2, 4);

        // Only channel 3 after reset
        apply_reset();
        req = 4'b1000;
        step();
        grant(2'd3, 4);
        grant(2'd3, 4);

        // Early drop after two grant cycles
        apply_reset();
        req = 4'b0010;
        step();
        chk("drop_c1_en", enable, 1'b1);
        chk("drop_c1_sel", sel, 2'd1);
        chk("drop_c1_done", grant_done, 1'b0);
        step();
        chk("drop_c2_en", enable, 1'b1);
        chk("drop_c2_done", grant_done, 1'b0);
        step();
        req = 4'b0000;
        #1;
        chk("drop_c3_en", enable, 1'b1);
        chk("drop_c3_done", grant_done, 1'b1);
        step();
`ifdef SCAN_GAP_EN
        chk("drop_gap_en", enable, 1'b0);
        chk("drop_gap_state", dbg_state, GAP);
        step();
`endif
        chk("drop_idle_en", enable, 1'b0);
        chk("drop_idle_state", dbg_state, IDLE);
        chk("drop_idle_done", grant_done, 1'b0);
        step();
        chk("drop_stay_state", dbg_state, IDLE);

        // Hold for three cycles mid-grant stretches enable to seven cycles
        apply_reset();
        req = 4'b0001;
        step();
        chk("hold_c1_en", enable, 1'b1);
        chk("hold_c1_done", grant_done, 1'b0);
        step();
        hold = 1'b1;
        #1;
        chk("hold_c2_en", enable, 1'b1);
        chk("hold_c2_done", grant_done, 1'b0);
        step();
        chk("hold_c3_en", enable, 1'b1);
        chk("hold_c3_done", grant_done, 1'b0);
        step();
        chk("hold_c4_en", enable, 1'b1);
        chk("hold_c4_done", grant_done, 1'b0);
        step();
        hold = 1'b0;
        #1;
        chk("hold_c5_en", enable, 1'b1);
        chk("hold_c5_done", grant_done, 1'b0);
        step();
        chk("hold_c6_en", enable, 1'b1);
        chk("hold_c6_done", grant_done, 1'b0);
        step();
        chk("hold_c7_en", enable, 1'b1);
        chk("hold_c7_done", grant_done, 1'b1);
        // Hold on the final cycle suppresses grant_done and freezes the grant
        hold = 1'b1;
        #1;
        chk("hold_last_done", grant_done, 1'b0);
        chk("hold_last_en", enable, 1'b1);
        step();
        chk("hold_frz_en", enable, 1'b1);
        chk("hold_frz_sel", sel, 2'd0);
        chk("hold_frz_done", grant_done, 1'b0);
        hold = 1'b0;
        #1;
        chk("hold_rel_done", grant_done, 1'b1);
        step();
`ifdef SCAN_GAP_EN
        chk("hold_gap_en", enable, 1'b0);
        step();
`endif
        chk("hold_regrant_en", enable, 1'b1);
        chk("hold_regrant_sel", sel, 2'd0);

        // Two requesters back to back
        apply_reset();
        req = 4'b0011;
        step();
        grant(2'd0, 4);
        grant(2'd1, 4);
        grant(2'd0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
